// File: rtl/pmod_unit_pkg.sv
// rtl/pmod_unit_pkg.sv - shared RGB colour type and colour constants for the PMOD LED unit
package pmod_unit_pkg;

  // Colour bits are ordered {r, g, b}
  typedef logic [2:0] rgb_t;

  localparam rgb_t OFF   = 3'b000;
  localparam rgb_t RED   = 3'b100;
  localparam rgb_t GREEN = 3'b010;
  localparam rgb_t BLUE  = 3'b001;
  localparam rgb_t CYAN  = 3'b011;

endpackage

// File: rtl/pmod_event_hold.sv
// rtl/pmod_event_hold.sv - rising-edge event capture and colour hold timer for LED1
module pmod_event_hold
  import pmod_unit_pkg::*;
#(
  parameter int HOLD_CYCLES = 2048
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_error,
  input  logic i_succes,
  output rgb_t o_color_next
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic          r_err_d;
  logic          r_suc_d;
  logic [CW-1:0] r_cnt;
  rgb_t          r_color;

  logic          w_err_rise;
  logic          w_suc_rise;
  logic [CW-1:0] w_cnt_next;
  rgb_t          w_color_next;

  // Next hold state: error wins, success is ignored while red is held, else count down
  always_comb begin
    w_err_rise   = i_error & ~r_err_d;
    w_suc_rise   = i_succes & ~r_suc_d;
    w_cnt_next   = r_cnt;
    w_color_next = r_color;
    if (w_err_rise) begin
      w_color_next = RED;
      w_cnt_next   = CW'(HOLD_CYCLES);
    end else if (w_suc_rise && (r_color != RED)) begin
      w_color_next = GREEN;
      w_cnt_next   = CW'(HOLD_CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        w_color_next = OFF;
      end
    end
  end

  // Edge-detect samples and hold counter/colour state
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_err_d <= 1'b0;
      r_suc_d <= 1'b0;
      r_cnt   <= '0;
      r_color <= OFF;
    end else begin
      r_err_d <= i_error;
      r_suc_d <= i_succes;
      r_cnt   <= w_cnt_next;
      r_color <= w_color_next;
    end
  end

  // The parent registers this together with the PWM gate, so LED1 sees no extra delay
  assign o_color_next = w_color_next;

endmodule

// File: rtl/pmod_unit.sv
// rtl/pmod_unit.sv - PMOD RGB LED status unit: LED0 state colour with blink, LED1 event colour, PWM dimming
module pmod_unit
  import pmod_unit_pkg::*;
#(
  parameter int HOLD_CYCLES = 2048,
  parameter int BLINK_HALF  = 512,
  parameter int PWM_BITS    = 4,
  parameter int DUTY        = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_init_done,
  input  logic i_idle,
  input  logic i_wait_cmd,
  input  logic i_error,
  input  logic i_succes,
  output logic o_led0_r,
  output logic o_led0_g,
  output logic o_led0_b,
  output logic o_led1_r,
  output logic o_led1_g,
  output logic o_led1_b
);

  localparam int  BW         = $clog2(BLINK_HALF + 1);
  localparam int  PWM_PERIOD = 2 ** PWM_BITS;
  localparam bit  ALWAYS_ON  = (DUTY >= PWM_PERIOD);

  logic [BW-1:0]       r_blink_cnt;
  logic                r_blink_off;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  rgb_t                r_led0;
  rgb_t                r_led1;

  logic                w_in_wait;
  logic                w_pwm_on;
  rgb_t                w_led0;
  rgb_t                w_led1;

  pmod_event_hold #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_event_hold (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_error      (i_error),
    .i_succes     (i_succes),
    .o_color_next (w_led1)
  );

  assign w_in_wait = i_init_done & i_wait_cmd;
  assign w_pwm_on  = ALWAYS_ON || (int'(r_pwm_cnt) < DUTY);

  // LED0 colour by system-state priority; blink phase comes from the free-running blink timer
  always_comb begin
    w_led0 = OFF;
    if (!i_init_done) begin
      w_led0 = RED;
    end else if (i_wait_cmd) begin
      w_led0 = r_blink_off ? OFF : BLUE;
    end else if (i_idle) begin
      w_led0 = GREEN;
    end else begin
      w_led0 = CYAN;
    end
  end

  // Blink timer runs only in the wait state and re-arms phase-on whenever it is left
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (!w_in_wait) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Free-running brightness counter, wraps at its natural width
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // Output registers: selected colours gated by the PWM window
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_led0 <= OFF;
      r_led1 <= OFF;
    end else begin
      r_led0 <= w_led0 & {3{w_pwm_on}};
      r_led1 <= w_led1 & {3{w_pwm_on}};
    end
  end

  assign o_led0_r = r_led0[2];
  assign o_led0_g = r_led0[1];
  assign o_led0_b = r_led0[0];
  assign o_led1_r = r_led1[2];
  assign o_led1_g = r_led1[1];
  assign o_led1_b = r_led1[0];

endmodule

// File: tb/tb_pmod_unit.sv
// tb/tb_pmod_unit.sv - scoreboard testbench for pmod_unit
module tb_pmod_unit;

  localparam logic [2:0] C_OFF   = 3'b000;
  localparam logic [2:0] C_RED   = 3'b100;
  localparam logic [2:0] C_GREEN = 3'b010;
  localparam logic [2:0] C_BLUE  = 3'b001;
  localparam logic [2:0] C_CYAN  = 3'b011;

  logic i_clock = 1'b0;
  logic i_reset, i_init_done, i_idle, i_wait_cmd, i_error, i_succes;
  logic o_led0_r, o_led0_g, o_led0_b, o_led1_r, o_led1_g, o_led1_b;
  logic p_led0_r, p_led0_g, p_led0_b, p_led1_r, p_led1_g, p_led1_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] sb_q[$];

  always #5 i_clock = ~i_clock;

  pmod_unit dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_init_done (i_init_done),
    .i_idle      (i_idle),
    .i_wait_cmd  (i_wait_cmd),
    .i_error     (i_error),
    .i_succes    (i_succes),
    .o_led0_r    (o_led0_r),
    .o_led0_g    (o_led0_g),
    .o_led0_b    (o_led0_b),
    .o_led1_r    (o_led1_r),
    .o_led1_g    (o_led1_g),
    .o_led1_b    (o_led1_b)
  );

  pmod_unit #(.DUTY(8), .PWM_BITS(4)) dut_pwm (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_init_done (i_init_done),
    .i_idle      (i_idle),
    .i_wait_cmd  (i_wait_cmd),
    .i_error     (i_error),
    .i_succes    (i_succes),
    .o_led0_r    (p_led0_r),
    .o_led0_g    (p_led0_g),
    .o_led0_b    (p_led0_b),
    .o_led1_r    (p_led1_r),
    .o_led1_g    (p_led1_g),
    .o_led1_b    (p_led1_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Push the expectation for the coming edge, then compare once the registered outputs settle
  task automatic cyc(input string tag, input logic [2:0] exp0, input logic [2:0] exp1);
    logic [5:0] e;
    sb_q.push_back({exp0, exp1});
    @(posedge i_clock);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_led0"}, {29'd0, o_led0_r, o_led0_g, o_led0_b}, {29'd0, e[5:3]});
      check({tag, "_led1"}, {29'd0, o_led1_r, o_led1_g, o_led1_b}, {29'd0, e[2:0]});
    end
  endtask

  initial begin
    int g_cnt;
    int rb_cnt;
    i_reset = 1'b0; i_init_done = 1'b0; i_idle = 1'b0;
    i_wait_cmd = 1'b0; i_error = 1'b0; i_succes = 1'b0;
    #2;

    // Reset state
    cyc("reset", C_OFF, C_OFF);
    check("reset_pwm_dut", {26'd0, p_led0_r, p_led0_g, p_led0_b, p_led1_r, p_led1_g, p_led1_b}, 32'd0);

    // Release with init not done -> red
    i_reset = 1'b1;
    cyc("init_red", C_RED, C_OFF);
    cyc("init_red2", C_RED, C_OFF);

    // Idle -> green, then busy -> cyan
    i_init_done = 1'b1; i_idle = 1'b1;
    for (int k = 0; k < 3; k++) cyc("idle_green", C_GREEN, C_OFF);
    i_idle = 1'b0;
    for (int k = 0; k < 3; k++) cyc("busy_cyan", C_CYAN, C_OFF);

    // Wait-for-command blink: 512 on, 512 off, repeating
    i_wait_cmd = 1'b1;
    for (int k = 0; k < 2048; k++)
      cyc("wait_blink", (((k / 512) % 2) == 0) ? C_BLUE : C_OFF, C_OFF);
    i_wait_cmd = 1'b0; i_idle = 1'b1;
    cyc("wait_exit", C_GREEN, C_OFF);

    // Error held 2 cycles, success pulse 3 cycles later is ignored
    for (int k = 0; k < 2060; k++) begin
      i_error  = (k < 2);
      i_succes = (k == 3);
      cyc("err_hold", C_GREEN, (k < 2048) ? C_RED : C_OFF);
    end
    i_error = 1'b0; i_succes = 1'b0;

    // Success, retriggered 50 cycles later extends the hold
    for (int k = 0; k < 2110; k++) begin
      i_succes = (k == 0) || (k == 50);
      cyc("suc_hold", C_GREEN, (k < 2098) ? C_GREEN : C_OFF);
    end
    i_succes = 1'b0;

    // Simultaneous edges -> error wins
    for (int k = 0; k < 20; k++) begin
      i_error  = (k == 0);
      i_succes = (k == 0);
      cyc("both_edges", C_GREEN, C_RED);
    end

    // Reset mid-hold aborts it
    i_reset = 1'b0;
    cyc("mid_reset", C_OFF, C_OFF);
    check("mid_reset_pwm_dut", {26'd0, p_led0_r, p_led0_g, p_led0_b, p_led1_r, p_led1_g, p_led1_b}, 32'd0);
    i_reset = 1'b1;
    for (int k = 0; k < 10; k++) cyc("after_reset", C_GREEN, C_OFF);

    // PWM at DUTY=8: exactly 8 of every 16 cycles lit
    for (int w = 0; w < 2; w++) begin
      g_cnt = 0; rb_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        @(posedge i_clock);
        #1;
        g_cnt += int'(p_led0_g);
        rb_cnt += int'(p_led0_r) + int'(p_led0_b) + int'(p_led1_r) + int'(p_led1_g) + int'(p_led1_b);
      end
      check("pwm_on_count", g_cnt, 32'd8);
      check("pwm_unlit_count", rb_cnt, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmod_unit.md
PMOD_UNIT -- requirements
Module: pmod_unit

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2048; cycles an event colour stays on LED1.
REQ-002 SHALL have parameter BLINK_HALF, default 512; half-period in cycles of the LED0 wait blink.
REQ-003 SHALL have parameter PWM_BITS, default 4; width of the brightness PWM counter.
REQ-004 SHALL have parameter DUTY, default 16 (2**PWM_BITS); on-cycles per PWM period, where DUTY >= 2**PWM_BITS means always on.
REQ-005 SHALL have port i_clock, input, 1; single system clock, rising-edge.
REQ-006 SHALL have port i_reset, input, 1; synchronous, active-low reset.
REQ-007 SHALL have port i_init_done, input, 1; ADC/system initialisation complete (level).
REQ-008 SHALL have port i_idle, input, 1; system idle (level).
REQ-009 SHALL have port i_wait_cmd, input, 1; waiting for a command (level).
REQ-010 SHALL have port i_error, input, 1; error event, pulse of any length.
REQ-011 SHALL have port i_succes, input, 1; success event, pulse of any length.
REQ-012 SHALL have ports o_led0_r/g/b and o_led1_r/g/b, output, 1 each; active-high RGB LED drives.

Function
REQ-013 SHALL register all outputs; an input change is visible one clock after the sampling edge.
REQ-014 SHALL set LED0 by priority: !i_init_done -> red; else i_wait_cmd -> blue blinking; else i_idle -> green; else cyan (g+b).
REQ-015 SHALL make the blink free-running: toggle every BLINK_HALF cycles while in the wait state; restart phase-on whenever the wait state is entered.
REQ-016 SHALL detect events on rising edges only (previous-sample register); a level held high counts once.
REQ-017 SHALL, on an i_error rising edge, set LED1 to red and load the hold counter with HOLD_CYCLES.
REQ-018 SHALL, on an i_succes rising edge, set LED1 to green and load the hold counter, unless red is currently being held.
REQ-019 SHALL, when both edges occur in the same cycle, apply error only.
REQ-020 SHALL restart the full hold on a repeated edge of the held colour.
REQ-021 SHALL turn LED1 off (000) when the counter reaches 0; the colour is on for exactly HOLD_CYCLES cycles after the edge.
REQ-022 SHALL AND all six outputs with the PWM gate: on while counter < DUTY; the counter wraps at 2**PWM_BITS.
REQ-023 SHALL treat inputs as synchronous to i_clock; no synchronisers are included.

Reset
REQ-024 SHALL, while i_reset=0 at a clock edge, clear all six outputs, the hold counter, blink counter/phase, PWM counter and edge registers.
REQ-025 SHALL make the first clock after reset release show LED0 per REQ-014; events pending at reset are discarded.
REQ-026 SHALL abort any hold when reset is asserted mid-hold; LED1 stays off after release.

Structure
REQ-027 SHALL place the colour constants in shared package pmod_unit_pkg: OFF=000, RED=100, GREEN=010, BLUE=001, CYAN=011, in r,g,b order.
REQ-028 SHALL place the LED1 edge detect and hold timer in sub-module pmod_event_hold, with HOLD_CYCLES as its parameter.
REQ-029 SHALL keep the LED0 selection, blink and PWM logic in pmod_unit.

Verification
REQ-030 SHALL check: reset low 1 cycle, then release with init_done=0 -> led0=100, led1=000.
REQ-031 SHALL check: init_done=1, idle=1, wait_cmd=0 -> led0=010 one cycle later; idle=0 -> 011; wait_cmd=1 -> 001 for 512 cycles, then 000 for 512 cycles, repeating.
REQ-032 SHALL check: i_error high 2 cycles -> led1=100 for exactly 2048 cycles, then 000; a success pulse 3 cycles after the error leaves led1 red.
REQ-033 SHALL check: success pulse while idle -> led1=010 for 2048 cycles; a second success pulse 50 cycles later extends green to 2098 cycles total.
REQ-034 SHALL check: error and success rising in the same cycle -> led1=100.
REQ-035 SHALL check: with DUTY=8 and PWM_BITS=4, each lit output is high exactly 8 of every 16 cycles.
